dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Initiator side of the data-memory interface. Accepts byte/halfword/word load and store requests from the CPU datapath and drives the word-wide data memory's addr/dataIn/wrEnable; captures its dataOut.
- The memory registers address, write data and write enable on clk, so read data is valid in the cycle after the address is presented.
- Sub-word stores are done as read-modify-write.
- Loads are aligned, lane-extracted and sign- or zero-extended.

Parameters:
- DATA_WIDTH, 32, data path width; fixed at 32 because the lane logic assumes 4 bytes.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- req  input  1  request strobe; sampled only in IDLE
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  input  1  sign-extend the load result
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  DATA_WIDTH  store data, right-justified
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  valid only with done; misaligned or illegal size
- rdata  output  DATA_WIDTH  load result; held until next done
- mem_addr  output  ADDR_WIDTH  word-aligned byte address to memory, bits [1:0] = 0
- mem_wdata  output  DATA_WIDTH  write data to memory
- mem_we  output  1  memory write enable
- mem_rdata  input  DATA_WIDTH  memory read data

Behaviour:
- Reset (async, rst=0):
  - state goes to IDLE.
  - busy, done, err, mem_we = 0; rdata, mem_addr, mem_wdata = 0.
  - Reset mid-operation abandons the access. mem_we drops immediately and no write is issued afterwards.
- All outputs are registered.
- Accept: in IDLE with req=1, latch req_we, req_size, req_signed, req_addr, req_wdata at the clock edge. req is ignored in all other states.
- Error check at accept:
  - halfword with addr[0]=1 is misaligned;
  - word with addr[1:0]≠0 is misaligned;
  - size 11 is illegal.
  - On any error, go to DONE with err=1. No memory access occurs and mem_we stays 0.
- States: IDLE, ISSUE, WAIT, WRITE, DONE.
- Transitions:
  - IDLE --valid word store--> WRITE
  - IDLE --load or sub-word store--> ISSUE
  - IDLE --error--> DONE
  - ISSUE --> WAIT
  - WAIT --load--> DONE
  - WAIT --sub-word store--> WRITE
  - WRITE --> DONE
  - DONE --> IDLE
- mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}. It is driven from ISSUE through WRITE and held otherwise.
- mem_we = 1 only in WRITE, for exactly one cycle.
- WAIT captures mem_rdata into an internal word register at the end of the cycle.
- Lanes are little-endian: byte k = bits [8k+7:8k], with k = addr[1:0]. A halfword uses lanes {2h+1, 2h}, with h = addr[1].
- Load result:
  - the selected lane(s) are shifted to bit 0;
  - upper bits are filled with the lane MSB if req_signed=1, else 0;
  - a word load is passed through unchanged;
  - rdata is updated on entering DONE.
- Store merge: the captured word with the selected lane(s) replaced by the low 8/16 bits of req_wdata. A word store uses req_wdata directly.
- Latency, counted in cycles after the accept edge, with done high in the cycle listed:
  - load: done in cycle 3;
  - word store: done in cycle 2;
  - sub-word store: done in cycle 4;
  - error: done in cycle 1.
- done and err are high only in DONE.
- The earliest next accept is the IDLE cycle after DONE. This guarantees the memory's deferred write has committed before a following read address is latched.
- On a load, rdata is unchanged when err=1.

Test Plan:
- Load word: memory word 0x40 = 0xDEADBEEF, load word at 0x40 -> done in cycle 3 after accept, rdata=0xDEADBEEF, err=0, mem_we never 1.
- Signed/unsigned byte loads at 0x43 from word 0x80FF1234:
  - signed -> rdata=0xFFFFFF80;
  - unsigned -> 0x00000080.
  - Signed halfword load at 0x42 -> 0xFFFF80FF.
- Byte store: word 0x40 = 0x11223344, store byte 0xAA at 0x41 -> one WRITE cycle with mem_wdata=0x1122AA44 and mem_addr=0x40, done in cycle 4; a following word load at 0x40 returns 0x1122AA44.
- Word store 0xCAFEF00D at 0x44 -> mem_we high exactly one cycle, done in cycle 2; readback returns 0xCAFEF00D.
- Errors: word load at 0x42, halfword store at 0x45, size=11 -> done and err in cycle 1, mem_we=0, memory contents and rdata unchanged.
- Reset during the WAIT cycle of a byte store -> busy=0 and mem_we=0 immediately; target word unchanged; a new request after reset completes normally. A req pulsed while busy is ignored (no extra done).

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// rtl/dmem_access_ctrl_if.sv - CPU request and data-memory bus bundle for dmem_access_ctrl
`timescale 1ns/1ps

interface dmem_access_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) ();
   logic                  req;
   logic                  req_we;
   logic [1:0]            req_size;
   logic                  req_signed;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [DATA_WIDTH-1:0] rdata;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // The controller is the slave of the CPU request and the driver of the memory pins.
   modport slave (
      input  req, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
      output busy, done, err, rdata, mem_addr, mem_wdata, mem_we
   );

   modport master (
      output req, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
      input  busy, done, err, rdata, mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - data-memory initiator: sized loads with extension, RMW sub-word stores
`timescale 1ns/1ps

module dmem_access_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   dmem_access_ctrl_if.slave   bus
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [DATA_WIDTH-1:0] BYTE_MASK = DATA_WIDTH'(32'h0000_00FF);
   localparam logic [DATA_WIDTH-1:0] HALF_MASK = DATA_WIDTH'(32'h0000_FFFF);

   state_t                state_q, state_d;
   logic                  we_q, we_d;
   logic [1:0]            size_q, size_d;
   logic                  sgn_q, sgn_d;
   logic [1:0]            off_q, off_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic                  mem_we_q, mem_we_d;

   logic                  req_bad;
   logic [4:0]            lane_sh;
   logic [DATA_WIDTH-1:0] lane_mask;
   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] load_val;
   logic [DATA_WIDTH-1:0] merged;

   // Lane position of the latched access applied to the word arriving in WAIT.
   always_comb begin
      lane_sh   = (size_q == SZ_BYTE) ? {off_q, 3'b000} : {off_q[1], 4'b0000};
      lane_mask = ((size_q == SZ_BYTE) ? BYTE_MASK : HALF_MASK) << lane_sh;
      shifted   = bus.mem_rdata >> lane_sh;
      merged    = (bus.mem_rdata & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
      case (size_q)
         SZ_BYTE: load_val = {{(DATA_WIDTH-8){sgn_q & shifted[7]}}, shifted[7:0]};
         SZ_HALF: load_val = {{(DATA_WIDTH-16){sgn_q & shifted[15]}}, shifted[15:0]};
         default: load_val = bus.mem_rdata;
      endcase
   end

   always_comb begin
      req_bad = (bus.req_size == 2'b11)
              || (bus.req_size == SZ_HALF && bus.req_addr[0])
              || (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00);
   end

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      size_d      = size_q;
      sgn_d       = sgn_q;
      off_d       = off_q;
      wdata_d     = wdata_q;
      err_d       = 1'b0;
      rdata_d     = rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               we_d    = bus.req_we;
               size_d  = bus.req_size;
               sgn_d   = bus.req_signed;
               off_d   = bus.req_addr[1:0];
               wdata_d = bus.req_wdata;
               if (req_bad) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end else begin
                  mem_addr_d = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                  if (bus.req_we && bus.req_size == SZ_WORD) begin
                     state_d     = S_WRITE;
                     mem_wdata_d = bus.req_wdata;
                  end else begin
                     state_d = S_ISSUE;
                  end
               end
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (we_q) begin
               state_d     = S_WRITE;
               mem_wdata_d = merged;
            end else begin
               state_d = S_DONE;
               rdata_d = load_val;
            end
         end
         S_WRITE: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d   = (state_d != S_IDLE);
      done_d   = (state_d == S_DONE);
      mem_we_d = (state_d == S_WRITE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         sgn_q       <= 1'b0;
         off_q       <= 2'b00;
         wdata_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         size_q      <= size_d;
         sgn_q       <= sgn_d;
         off_q       <= off_d;
         wdata_q     <= wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.rdata     = rdata_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_we    = mem_we_q;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - randomized bench for dmem_access_ctrl against a byte-array reference
`timescale 1ns/1ps

module tb_dmem_access_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dmem_access_ctrl_if bus ();

   dmem_access_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Word memory that registers addr/data/we and commits the write one edge later.
   logic [31:0] mem_words [0:63];
   logic [31:0] a_r = '0;
   logic [31:0] d_r = '0;
   logic        w_r = 1'b0;
   logic        pl_en = 1'b0;
   logic [5:0]  pl_idx = '0;
   logic [31:0] pl_val = '0;

   always @(posedge clk) begin
      if (w_r) mem_words[a_r[7:2]] <= d_r;
      if (pl_en) mem_words[pl_idx] <= pl_val;
      a_r <= bus.mem_addr;
      d_r <= bus.mem_wdata;
      w_r <= bus.mem_we;
   end
   assign bus.mem_rdata = mem_words[a_r[7:2]];

   logic [7:0]  ref_mem [0:255];
   logic [31:0] exp_rdata;
   int n_checks = 0;
   int n_errs   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input int a);
      int b;
      b = a & 32'hFC;
      return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
   endfunction

   task automatic preload(input int a, input logic [31:0] w);
      int b;
      b = a & 32'hFC;
      @(negedge clk);
      pl_en  = 1'b1;
      pl_idx = b[7:2];
      pl_val = w;
      @(negedge clk);
      pl_en = 1'b0;
      for (int i = 0; i < 4; i++) ref_mem[b+i] = w[8*i +: 8];
   endtask

   task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                         input int a, input logic [31:0] wd, input logic poke);
      logic        e_err;
      int          e_lat, e_wes, cyc, wes, extra;
      logic [31:0] e_load, e_word;
      logic [15:0] hv;
      logic signed [7:0]  sb;
      logic signed [15:0] sh;
      e_err = (size == 2'b11) || (size == 2'b01 && a[0]) || (size == 2'b10 && a[1:0] != 2'b00);
      e_lat = e_err ? 1 : (!we ? 3 : (size == 2'b10 ? 2 : 4));
      e_wes = (we && !e_err) ? 1 : 0;
      e_load = '0;
      if (!e_err && !we) begin
         case (size)
            2'b00: begin
               sb = ref_mem[a];
               e_load = sgn ? 32'(sb) : {24'b0, ref_mem[a]};
            end
            2'b01: begin
               hv = {ref_mem[a+1], ref_mem[a]};
               sh = hv;
               e_load = sgn ? 32'(sh) : {16'b0, hv};
            end
            default: e_load = ref_word(a);
         endcase
      end
      if (!e_err && we) begin
         ref_mem[a] = wd[7:0];
         if (size != 2'b00) ref_mem[a+1] = wd[15:8];
         if (size == 2'b10) begin
            ref_mem[a+2] = wd[23:16];
            ref_mem[a+3] = wd[31:24];
         end
      end
      e_word = ref_word(a);

      @(negedge clk);
      bus.req = 1'b1;  bus.req_we = we;  bus.req_size = size;
      bus.req_signed = sgn;  bus.req_addr = 32'(a);  bus.req_wdata = wd;
      @(negedge clk);
      bus.req = 1'b0;
      chk("busy_c1", 32'(bus.busy), 32'd1);
      wes = 0;
      for (cyc = 1; cyc <= 8; cyc++) begin
         if (cyc > 1) @(negedge clk);
         if (bus.mem_we) begin
            wes++;
            chk("wr_addr", bus.mem_addr, 32'(a) & 32'hFFFF_FFFC);
            chk("wr_data", bus.mem_wdata, e_word);
         end
         if (poke && cyc == 2) begin
            bus.req = 1'b1;  bus.req_we = 1'b1;  bus.req_size = 2'b10;
            bus.req_addr = 32'h0000_0080;  bus.req_wdata = $urandom;
         end
         if (cyc == 3) bus.req = 1'b0;
         if (bus.done) break;
      end
      if (cyc > 8) chk("done_timeout", 32'd0, 32'd1);
      chk("latency", 32'(cyc), 32'(e_lat));
      chk("err", 32'(bus.err), 32'(e_err));
      chk("we_cycles", 32'(wes), 32'(e_wes));
      if (!e_err && !we) exp_rdata = e_load;
      chk("rdata", bus.rdata, exp_rdata);
      @(negedge clk);
      chk("done_drop", 32'(bus.done), 32'd0);
      chk("mem_word", mem_words[a[7:2]], ref_word(a));
      if (poke) begin
         extra = 0;
         repeat (4) begin
            @(negedge clk);
            if (bus.done || bus.mem_we) extra++;
         end
         chk("ignored_req", 32'(extra), 32'd0);
      end
   endtask

   initial begin
      logic [31:0] keep;
      bus.req = 1'b0;  bus.req_we = 1'b0;  bus.req_size = 2'b00;
      bus.req_signed = 1'b0;  bus.req_addr = '0;  bus.req_wdata = '0;
      exp_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy",   32'(bus.busy),   32'd0);
      chk("rst_done",   32'(bus.done),   32'd0);
      chk("rst_err",    32'(bus.err),    32'd0);
      chk("rst_we",     32'(bus.mem_we), 32'd0);
      chk("rst_rdata",  bus.rdata,       32'd0);
      chk("rst_maddr",  bus.mem_addr,    32'd0);
      chk("rst_mwdata", bus.mem_wdata,   32'd0);
      for (int i = 0; i < 256; i += 4) preload(i, $urandom);
      rst = 1'b1;

      preload(32'h40, 32'hDEADBEEF);
      do_req(1'b0, 2'b10, 1'b0, 32'h40, '0, 1'b0);
      chk("tp_lw", bus.rdata, 32'hDEADBEEF);

      preload(32'h40, 32'h80FF1234);
      do_req(1'b0, 2'b00, 1'b1, 32'h43, '0, 1'b0);
      chk("tp_lb_s", bus.rdata, 32'hFFFFFF80);
      do_req(1'b0, 2'b00, 1'b0, 32'h43, '0, 1'b0);
      chk("tp_lb_u", bus.rdata, 32'h00000080);
      do_req(1'b0, 2'b01, 1'b1, 32'h42, '0, 1'b0);
      chk("tp_lh_s", bus.rdata, 32'hFFFF80FF);

      preload(32'h40, 32'h11223344);
      do_req(1'b1, 2'b00, 1'b0, 32'h41, 32'h000000AA, 1'b0);
      do_req(1'b0, 2'b10, 1'b0, 32'h40, '0, 1'b0);
      chk("tp_sb_rb", bus.rdata, 32'h1122AA44);

      do_req(1'b1, 2'b10, 1'b0, 32'h44, 32'hCAFEF00D, 1'b0);
      do_req(1'b0, 2'b10, 1'b0, 32'h44, '0, 1'b1);
      chk("tp_sw_rb", bus.rdata, 32'hCAFEF00D);

      do_req(1'b0, 2'b10, 1'b0, 32'h42, '0, 1'b0);
      do_req(1'b1, 2'b01, 1'b0, 32'h45, 32'h0000BEEF, 1'b0);
      do_req(1'b0, 2'b11, 1'b0, 32'h48, '0, 1'b0);

      // Abort a byte store while it sits in WAIT.
      preload(32'h50, 32'h55667788);
      keep = 32'h55667788;
      @(negedge clk);
      bus.req = 1'b1;  bus.req_we = 1'b1;  bus.req_size = 2'b00;
      bus.req_signed = 1'b0;  bus.req_addr = 32'h52;  bus.req_wdata = 32'h000000EE;
      @(negedge clk);
      bus.req = 1'b0;
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_busy", 32'(bus.busy),   32'd0);
      chk("abort_we",   32'(bus.mem_we), 32'd0);
      chk("abort_done", 32'(bus.done),   32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_mem", mem_words[32'h50 >> 2], keep);
      exp_rdata = '0;
      do_req(1'b1, 2'b01, 1'b0, 32'h52, 32'h0000ABCD, 1'b0);
      do_req(1'b0, 2'b10, 1'b0, 32'h50, '0, 1'b0);
      chk("abort_after", bus.rdata, 32'hABCD7788);

      for (int n = 0; n < 150; n++) begin
         do_req(1'($urandom), 2'($urandom), 1'($urandom), int'($urandom_range(0, 255)),
                $urandom, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end
endmodule
